// File: rtl/sy_ppl_fetch_realign.sv
// Fetch realignment: splits 32-bit fetch words into RVC/RVI instructions, stitches
// instructions that straddle word boundaries, and registers them toward the instruction buffer.
module sy_ppl_fetch_realign #(
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned AW              = 64
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  if_valid_i,
  input  logic [AW-1:0]                         if_addr_i,
  input  logic [31:0]                           if_data_i,
  input  logic                                  if_ex_i,
  output logic                                  if_ready_o,
  input  logic                                  buf_ready_i,
  output logic [INSTR_PER_FETCH-1:0]            buf_valid_o,
  output logic [INSTR_PER_FETCH-1:0][AW-1:0]    buf_addr_o,
  output logic [INSTR_PER_FETCH-1:0][31:0]      buf_instr_o,
  output logic                                  buf_ex_o
);

  logic [INSTR_PER_FETCH-1:0]         valid_q, valid_d;
  logic [INSTR_PER_FETCH-1:0][AW-1:0] addr_q, addr_d;
  logic [INSTR_PER_FETCH-1:0][31:0]   instr_q, instr_d;
  logic                               ex_q, ex_d;

  // Lower half of a 32-bit instruction whose upper half arrives with the next word.
  logic                               unaligned_q, unaligned_d;
  logic [15:0]                        unaligned_half_q, unaligned_half_d;
  logic [AW-1:0]                      unaligned_addr_q, unaligned_addr_d;

  logic          accept;
  logic [15:0]   lo, hi;
  logic          lo_rvc, hi_rvc;
  logic [AW-1:0] hi_addr;
  logic          take_hi;
  logic          hi_slot;

  assign lo     = if_data_i[15:0];
  assign hi     = if_data_i[31:16];
  assign lo_rvc = (lo[1:0] != 2'b11);
  assign hi_rvc = (hi[1:0] != 2'b11);

  // The upper halfword sits at addr+2 for word-aligned fetches and at addr itself for
  // halfword-aligned redirect targets.
  assign hi_addr = if_addr_i[1] ? if_addr_i : if_addr_i + AW'(2);

  assign if_ready_o = ~flush_i & (~(|valid_q) | buf_ready_i);
  assign accept     = if_valid_i & if_ready_o;

  always_comb begin
    valid_d          = valid_q;
    addr_d           = addr_q;
    instr_d          = instr_q;
    ex_d             = ex_q;
    unaligned_d      = unaligned_q;
    unaligned_half_d = unaligned_half_q;
    unaligned_addr_d = unaligned_addr_q;
    take_hi          = 1'b0;
    hi_slot          = 1'b0;

    if (flush_i) begin
      valid_d     = '0;
      unaligned_d = 1'b0;
    end else if (accept) begin
      valid_d     = '0;
      addr_d      = '0;
      instr_d     = '0;
      ex_d        = 1'b0;
      unaligned_d = 1'b0;

      if (if_ex_i) begin
        valid_d[0] = 1'b1;
        ex_d       = 1'b1;
        addr_d[0]  = unaligned_q ? unaligned_addr_q : if_addr_i;
      end else if (unaligned_q) begin
        valid_d[0] = 1'b1;
        addr_d[0]  = unaligned_addr_q;
        instr_d[0] = {lo, unaligned_half_q};
        take_hi    = 1'b1;
      end else if (!if_addr_i[1]) begin
        valid_d[0] = 1'b1;
        addr_d[0]  = if_addr_i;
        if (lo_rvc) begin
          instr_d[0] = {16'h0000, lo};
          take_hi    = 1'b1;
        end else begin
          instr_d[0] = if_data_i;
        end
      end else begin
        take_hi = 1'b1;
      end

      // Upper half lands in the first free slot, or is parked if it starts an RVI.
      if (take_hi) begin
        hi_slot = valid_d[0];
        if (hi_rvc) begin
          valid_d[hi_slot] = 1'b1;
          addr_d[hi_slot]  = hi_addr;
          instr_d[hi_slot] = {16'h0000, hi};
        end else begin
          unaligned_d      = 1'b1;
          unaligned_half_d = hi;
          unaligned_addr_d = hi_addr;
        end
      end
    end else if (buf_ready_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q          <= '0;
      addr_q           <= '0;
      instr_q          <= '0;
      ex_q             <= 1'b0;
      unaligned_q      <= 1'b0;
      unaligned_half_q <= '0;
      unaligned_addr_q <= '0;
    end else begin
      valid_q          <= valid_d;
      addr_q           <= addr_d;
      instr_q          <= instr_d;
      ex_q             <= ex_d;
      unaligned_q      <= unaligned_d;
      unaligned_half_q <= unaligned_half_d;
      unaligned_addr_q <= unaligned_addr_d;
    end
  end

  assign buf_valid_o = valid_q;
  assign buf_addr_o  = addr_q;
  assign buf_instr_o = instr_q;
  assign buf_ex_o    = ex_q;

endmodule
